// File: rtl/mdl_cmdreg_pkg.sv
// Shared types and constants for the bubble memory command register.
package mdl_cmdreg_pkg;

    // Request lifecycle as seen by the controller FSM.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

    // CPU register addresses.
    localparam logic [1:0] ADDR_CMD     = 2'd0;
    localparam logic [1:0] ADDR_PAGE_LO = 2'd1;
    localparam logic [1:0] ADDR_PAGE_HI = 2'd2;
    localparam logic [1:0] ADDR_ERR_CLR = 2'd3;

    // Status byte bit positions.
    localparam int STS_RDREQ  = 0;
    localparam int STS_WRREQ  = 1;
    localparam int STS_BUSY   = 2;
    localparam int STS_DONE   = 3;
    localparam int STS_REJECT = 4;
    localparam int STS_ERR    = 5;
    localparam int STS_RUN    = 6;

endpackage

// File: rtl/mdl_cmdreg_if.sv
// CPU bus of the command register. Names are from the register's point of view.
interface mdl_cmdreg_if;
    logic       i_CS_n;
    logic       i_RW;
    logic [1:0] i_AB;
    logic [7:0] i_DB;
    logic [7:0] o_DB;
    logic       o_DB_OE;

    modport master (output i_CS_n, i_RW, i_AB, i_DB, input o_DB, o_DB_OE);
    modport slave  (input i_CS_n, i_RW, i_AB, i_DB, output o_DB, o_DB_OE);
endinterface

// File: rtl/mdl_cmdreg_cpusync.sv
// Brings the asynchronous CPU cycle into the i_MCLK domain: CS_n synchronizer,
// address/data/direction capture and one-cycle commit pulses.
module submdl_cpusync (
    input  logic       i_MCLK,
    input  logic       i_RST_n,
    input  logic       cs_n,
    input  logic       rw,
    input  logic [1:0] ab,
    input  logic [7:0] db,
    output logic       cs_active,
    output logic [1:0] cap_ab,
    output logic [7:0] cap_db,
    output logic       wr_commit,
    output logic       rd_commit
);
    logic cs_s1, cs_s2, cs_s3;
    logic cap_rw;
    logic commit;

    // Two-flop synchronizer plus one delay stage for edge detection; idle high.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cs_s1 <= 1'b1;
            cs_s2 <= 1'b1;
            cs_s3 <= 1'b1;
        end else begin
            cs_s1 <= cs_n;
            cs_s2 <= cs_s1;
            cs_s3 <= cs_s2;
        end
    end

    // Track bus contents while the cycle is active; frozen once CS_n is seen high.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cap_ab <= 2'd0;
            cap_db <= 8'd0;
            cap_rw <= 1'b0;
        end else if (!cs_s2) begin
            cap_ab <= ab;
            cap_db <= db;
            cap_rw <= rw;
        end
    end

    assign cs_active = ~cs_s2;
    assign commit    = cs_s2 & ~cs_s3;
    assign wr_commit = commit & ~cap_rw;
    assign rd_commit = commit & cap_rw;

endmodule

// File: rtl/mdl_cmdreg.sv
// CPU-facing command register: latches page read/write requests for the
// controller FSM and reports request/busy/done/reject/system status.
//
// Request handshake: RDREQ/WRREQ are levels raised by an accepted command and
// held, with o_PAGE stable, until the FSM strobes i_CMDREG_RST_n low on a CLK2M
// enable; i_CMD_ACCEPTED_n only moves PENDING to BUSY and never drops a request.
module mdl_cmdreg
    import mdl_cmdreg_pkg::*;
#(
    parameter int PAGE_W = 12
) (
    input  logic              i_MCLK,
    input  logic              i_RST_n,
    input  logic              i_CLK2M_PCEN_n,
    mdl_cmdreg_if.slave       cpu,
    input  logic              i_CMDREG_RST_n,
    input  logic              i_CMD_ACCEPTED_n,
    input  logic              i_SYS_RUN_FLAG,
    input  logic              i_SYS_ERR_FLAG,
    output logic              o_CMDREG_RDREQ,
    output logic              o_CMDREG_WRREQ,
    output logic [PAGE_W-1:0] o_PAGE,
    output logic              o_ERR_CLR,
    output state_t            o_DBG_STATE
);
    logic       cs_active, wr_commit, rd_commit;
    logic [1:0] cap_ab;
    logic [7:0] cap_db;

    state_t state_q, state_d, st_mid;
    logic   rdreq_d, wrreq_d;
    logic   done_q, done_d, reject_q, reject_d;
    logic   rst_evt, acc_evt, cmd_wr, status_rd;
    logic [7:0] status, page_hi_rd, rd_mux;

    submdl_cpusync u_cpusync (
        .i_MCLK    (i_MCLK),
        .i_RST_n   (i_RST_n),
        .cs_n      (cpu.i_CS_n),
        .rw        (cpu.i_RW),
        .ab        (cpu.i_AB),
        .db        (cpu.i_DB),
        .cs_active (cs_active),
        .cap_ab    (cap_ab),
        .cap_db    (cap_db),
        .wr_commit (wr_commit),
        .rd_commit (rd_commit)
    );

    assign rst_evt   = ~i_CLK2M_PCEN_n & ~i_CMDREG_RST_n;
    assign acc_evt   = ~i_CLK2M_PCEN_n & ~i_CMD_ACCEPTED_n;
    assign cmd_wr    = wr_commit && (cap_ab == ADDR_CMD) && (cap_db[1:0] != 2'b00);
    assign status_rd = rd_commit && (cap_ab == ADDR_CMD);

    // Next state: FSM strobes apply first, then a command write is judged against the result.
    always_comb begin
        st_mid   = state_q;
        state_d  = state_q;
        rdreq_d  = o_CMDREG_RDREQ;
        wrreq_d  = o_CMDREG_WRREQ;
        done_d   = done_q;
        reject_d = reject_q;
        if (status_rd) begin
            done_d   = 1'b0;
            reject_d = 1'b0;
        end
        if (rst_evt && state_q != ST_IDLE) begin
            st_mid  = ST_IDLE;
            rdreq_d = 1'b0;
            wrreq_d = 1'b0;
            done_d  = 1'b1;
        end else if (acc_evt && state_q == ST_PENDING) begin
            st_mid = ST_BUSY;
        end
        state_d = st_mid;
        if (cmd_wr) begin
            if (st_mid != ST_IDLE || (&cap_db[1:0]) || !i_SYS_RUN_FLAG) begin
                reject_d = 1'b1;
            end else begin
                state_d = ST_PENDING;
                rdreq_d = cap_db[0];
                wrreq_d = cap_db[1];
            end
        end
    end

    // State, request levels and sticky flags.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q        <= ST_IDLE;
            o_CMDREG_RDREQ <= 1'b0;
            o_CMDREG_WRREQ <= 1'b0;
            done_q         <= 1'b0;
            reject_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            o_CMDREG_RDREQ <= rdreq_d;
            o_CMDREG_WRREQ <= wrreq_d;
            done_q         <= done_d;
            reject_q       <= reject_d;
        end
    end

    // Page register: writable only while no request is outstanding.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_PAGE <= '0;
        end else if (wr_commit && st_mid == ST_IDLE) begin
            if (cap_ab == ADDR_PAGE_LO) o_PAGE[7:0] <= cap_db;
            if (cap_ab == ADDR_PAGE_HI) o_PAGE[PAGE_W-1:8] <= cap_db[PAGE_W-9:0];
        end
    end

    // Error-clear pulse lasts exactly the one commit cycle.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) o_ERR_CLR <= 1'b0;
        else          o_ERR_CLR <= wr_commit && (cap_ab == ADDR_ERR_CLR) && cap_db[0];
    end

    // Status byte and read-data mux of the live address.
    always_comb begin
        status             = 8'd0;
        status[STS_RDREQ]  = o_CMDREG_RDREQ;
        status[STS_WRREQ]  = o_CMDREG_WRREQ;
        status[STS_BUSY]   = (state_q == ST_BUSY);
        status[STS_DONE]   = done_q;
        status[STS_REJECT] = reject_q;
        status[STS_ERR]    = i_SYS_ERR_FLAG;
        status[STS_RUN]    = i_SYS_RUN_FLAG;
        page_hi_rd              = 8'd0;
        page_hi_rd[PAGE_W-9:0]  = o_PAGE[PAGE_W-1:8];
        case (cpu.i_AB)
            ADDR_CMD:     rd_mux = status;
            ADDR_PAGE_LO: rd_mux = o_PAGE[7:0];
            ADDR_PAGE_HI: rd_mux = page_hi_rd;
            default:      rd_mux = 8'd0;
        endcase
    end

    // Registered read data, refreshed every clock.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) cpu.o_DB <= 8'd0;
        else          cpu.o_DB <= rd_mux;
    end

    assign cpu.o_DB_OE = cs_active & cpu.i_RW;
    assign o_DBG_STATE = state_q;

endmodule

// File: doc/mdl_cmdreg.md
# mdl_cmdreg

CPU-facing command register for the bubble memory controller. It latches read and write page requests from the host CPU bus and presents them to the controller FSM as level requests `RDREQ` and `WRREQ`, along with the target page number. It clears those requests when the FSM issues its command-register reset, and reports request, busy, done, reject and system-flag status back to the CPU. It is the issuing end of the request handshake that the FSM consumes.

## Interface
Parameters:
- `PAGE_W`, 12: width of the page number register.

Ports:
- `i_MCLK`  in  1  master clock; the only clock.
- `i_RST_n`  in  1  reset, asynchronous assert, active-low.
- `i_CLK2M_PCEN_n`  in  1  2 MHz clock enable, active-low. Qualifies all FSM-side sampling.
- `i_CS_n`  in  1  CPU chip select, asynchronous to `i_MCLK`.
- `i_RW`  in  1  CPU direction: 1 = read, 0 = write.
- `i_AB`  in  2  CPU register address.
- `i_DB`  in  8  CPU write data.
- `o_DB`  out  8  CPU read data.
- `o_DB_OE`  out  1  read-data output enable.
- `i_CMDREG_RST_n`  in  1  FSM clear-request strobe, active-low.
- `i_CMD_ACCEPTED_n`  in  1  FSM acceptance strobe, active-low.
- `i_SYS_RUN_FLAG`, `i_SYS_ERR_FLAG`  in  1 each  live system flags.
- `o_CMDREG_RDREQ`, `o_CMDREG_WRREQ`  out  1 each  page read / page write request levels.
- `o_PAGE`  out  `PAGE_W`  target page number.
- `o_ERR_CLR`  out  1  error-clear pulse, one `i_MCLK` wide.

## Operation
CPU register map:
- Address 0, write: command register. Bit0 = RD, bit1 = WR.
- Address 0, read: status byte (bit layout below).
- Address 1: page[7:0], read/write.
- Address 2: page[11:8], read/write. Write bits [3:0]; read back with bits [7:4] = 0.
- Address 3, write only: writing with bit0 = 1 pulses `o_ERR_CLR`. Reads return 0.

Status byte:
- bit0 = RDREQ
- bit1 = WRREQ
- bit2 = BUSY
- bit3 = DONE
- bit4 = REJECT
- bit5 = live `i_SYS_ERR_FLAG`
- bit6 = live `i_SYS_RUN_FLAG`
- bit7 = 0

State machine:
- IDLE → PENDING: on a valid command write. RDREQ or WRREQ is set from the written bits.
- PENDING → BUSY: on a sampled `i_CMD_ACCEPTED_n` = 0.
- PENDING or BUSY → IDLE: on a sampled `i_CMDREG_RST_n` = 0. This clears RDREQ/WRREQ and sets DONE.

Command write rules:
- A command write is rejected, setting the sticky REJECT flag with no state change, when any of these holds:
  - state ≠ IDLE;
  - RD and WR are both 1;
  - `i_SYS_RUN_FLAG` = 0.
- A command write with RD = WR = 0 is a no-op and is not rejected.
- Page writes are ignored while state ≠ IDLE. Writing the page during PENDING or BUSY does not corrupt `o_PAGE`.

Flag clearing:
- DONE and REJECT clear on the completion (CS_n rising edge) of a CPU read of address 0.
- A set event in that same cycle wins; the flag stays set.

Simultaneous events:
- RST strobe in IDLE: no effect on requests and DONE is not set.
- RST strobe in the same cycle as a command-write commit: apply the RST first, then evaluate the write against IDLE. A valid write is accepted.
- ACCEPTED strobe outside PENDING: ignored.

Reset values:
- state = IDLE.
- RDREQ, WRREQ, BUSY, DONE, REJECT = 0.
- `o_PAGE` = 0, `o_ERR_CLR` = 0, `o_DB_OE` = 0, `o_DB` = 0.

## Timing
- CPU cycles are asynchronous to `i_MCLK`.
  - `i_CS_n` passes through a 2-flop synchronizer on `i_MCLK`.
  - `i_AB`, `i_DB` and `i_RW` are captured every `i_MCLK` while the synchronized CS_n is low.
  - The commit happens on the synchronized CS_n rising edge.
- Write latency: request, page and `o_ERR_CLR` outputs update exactly 3 `i_MCLK` after the `i_CS_n` rising edge (2 sync stages + 1 register).
- Reads:
  - `o_DB_OE` = synchronized ~CS_n & `i_RW`.
  - `o_DB` is a registered mux of the addressed register, updated every `i_MCLK`.
- FSM strobes `i_CMDREG_RST_n` and `i_CMD_ACCEPTED_n` are sampled only on `i_MCLK` edges where `i_CLK2M_PCEN_n` = 0. State changes take effect on the same edge.
- Outputs hold between CLK2M enables except for CPU commits.
- `i_RST_n` asserted mid-operation returns everything to reset values immediately. The synchronizer flops are reset high (CS inactive).

## Structure
- Shared package `mdl_cmdreg_pkg`:
  - state enum (IDLE, PENDING, BUSY);
  - register address constants;
  - status bit index constants.
- One sub-module `submdl_cpusync`: CS_n synchronizer, capture of address/data/direction, and one-cycle read-commit and write-commit pulse generation.
- Top level: state machine, registers and read mux.

## Test plan
- Reset, then read address 0 → `o_DB` = 8'h40 with SYS_RUN = 1, SYS_ERR = 0. All requests are 0.
- Write page 1 = 8'h34, page 2 = 8'h01, command 8'h01 → `o_PAGE` = 12'h134 and RDREQ = 1, both 3 MCLK after CS rise. Status reads 8'h41.
- From PENDING: ACCEPTED pulse on a CLK2M enable → status 8'h45. Then RST pulse → RDREQ = 0 and status 8'h48. A second status read → 8'h40.
- Command 8'h03 in IDLE → no request and status 8'h50. Command 8'h02 during BUSY → WRREQ unchanged and REJECT set.
- RST strobe coincident with a command-write commit of 8'h02 in PENDING → ends PENDING with WRREQ = 1 and DONE = 1.
- `i_RST_n` low during BUSY → all outputs 0 asynchronously. Write 8'h01 to address 3 → `o_ERR_CLR` high for exactly 1 MCLK.
